// File: rtl/wash_cycle_sequencer.sv
// Wash-cycle controller: IDLE->FILL->WASH->RINSE->SPIN->IDLE with an integrated
// per-state down-timer, 1..MAX_PASS wash/rinse passes, pause/resume and abort.
module wash_cycle_sequencer #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned T_FILL   = 120_000_000,
    parameter int unsigned T_WASH   = 300_000_000,
    parameter int unsigned T_RINSE  = 120_000_000,
    parameter int unsigned T_SPIN   = 60_000_000,
    parameter int unsigned MAX_PASS = 3,
    parameter int unsigned PASS_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coin_in,
    input  logic [PASS_W-1:0] pass_req,
    input  logic              pause,
    input  logic              abort,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  remaining_time,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              paused,
    output logic              wash_done
);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_FILL  = 3'b001;
    localparam logic [2:0] S_WASH  = 3'b011;
    localparam logic [2:0] S_RINSE = 3'b010;
    localparam logic [2:0] S_SPIN  = 3'b110;

    localparam logic [CNT_W-1:0]  LD_FILL  = CNT_W'(T_FILL - 1);
    localparam logic [CNT_W-1:0]  LD_WASH  = CNT_W'(T_WASH - 1);
    localparam logic [CNT_W-1:0]  LD_RINSE = CNT_W'(T_RINSE - 1);
    localparam logic [CNT_W-1:0]  LD_SPIN  = CNT_W'(T_SPIN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);
    localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(MAX_PASS);

    logic [PASS_W-1:0] passes;
    logic [PASS_W-1:0] pass_clamped;

    always_comb begin
        pass_clamped = pass_req;
        if (pass_req == '0)
            pass_clamped = PASS_ONE;
        else if (pass_req > PASS_MAX)
            pass_clamped = PASS_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            remaining_time <= '0;
            pass_idx       <= '0;
            passes         <= '0;
            busy           <= 1'b0;
            paused         <= 1'b0;
            wash_done      <= 1'b0;
        end else begin
            wash_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    paused <= 1'b0;
                    if (coin_in && !abort) begin
                        state          <= S_FILL;
                        remaining_time <= LD_FILL;
                        pass_idx       <= PASS_ONE;
                        passes         <= pass_clamped;
                        busy           <= 1'b1;
                    end
                end
                S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                    // abort outranks pause, which in turn defers any pending expiry
                    if (abort) begin
                        state          <= S_IDLE;
                        remaining_time <= '0;
                        pass_idx       <= '0;
                        busy           <= 1'b0;
                        paused         <= 1'b0;
                    end else if (pause) begin
                        paused <= 1'b1;
                    end else begin
                        paused <= 1'b0;
                        if (remaining_time != '0) begin
                            remaining_time <= remaining_time - CNT_ONE;
                        end else begin
                            case (state)
                                S_FILL: begin
                                    state          <= S_WASH;
                                    remaining_time <= LD_WASH;
                                end
                                S_WASH: begin
                                    state          <= S_RINSE;
                                    remaining_time <= LD_RINSE;
                                end
                                S_RINSE: begin
                                    if (pass_idx < passes) begin
                                        state          <= S_WASH;
                                        remaining_time <= LD_WASH;
                                        pass_idx       <= pass_idx + PASS_ONE;
                                    end else begin
                                        state          <= S_SPIN;
                                        remaining_time <= LD_SPIN;
                                    end
                                end
                                default: begin
                                    state          <= S_IDLE;
                                    remaining_time <= '0;
                                    pass_idx       <= '0;
                                    busy           <= 1'b0;
                                    wash_done      <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    remaining_time <= '0;
                    pass_idx       <= '0;
                    passes         <= '0;
                    busy           <= 1'b0;
                    paused         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer: a vector table for a single-pass
// cycle plus hand-written multi-cycle sequences (passes, pause, abort, reset).
module tb_wash_cycle_sequencer;

    localparam logic [2:0] IDLE  = 3'b000;
    localparam logic [2:0] FILL  = 3'b001;
    localparam logic [2:0] WASH  = 3'b011;
    localparam logic [2:0] RINSE = 3'b010;
    localparam logic [2:0] SPIN  = 3'b110;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_in;
    logic [1:0] pass_req;
    logic       pause;
    logic       abort;

    logic [2:0] st1, st2;
    logic [7:0] rem1, rem2;
    logic [1:0] pi1, pi2;
    logic       busy1, busy2, pd1, pd2, done1, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wash_cycle_sequencer #(
        .CNT_W(8), .T_FILL(4), .T_WASH(6), .T_RINSE(3), .T_SPIN(2), .MAX_PASS(3), .PASS_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .pass_req(pass_req),
        .pause(pause), .abort(abort), .state(st1), .remaining_time(rem1),
        .pass_idx(pi1), .busy(busy1), .paused(pd1), .wash_done(done1)
    );

    // Second build with a lower pass ceiling, fed the same stimulus.
    wash_cycle_sequencer #(
        .CNT_W(8), .T_FILL(4), .T_WASH(6), .T_RINSE(3), .T_SPIN(2), .MAX_PASS(2), .PASS_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .pass_req(pass_req),
        .pause(pause), .abort(abort), .state(st2), .remaining_time(rem2),
        .pass_idx(pi2), .busy(busy2), .paused(pd2), .wash_done(done2)
    );

    typedef struct {
        logic       coin;
        logic [1:0] preq;
        logic       pause;
        logic       abort;
        logic [2:0] st;
        logic [7:0] rem;
        logic [1:0] pidx;
        logic       busy;
        logic       paused;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    logic [63:0] scode1, scode2, pcode1, pcode2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input int rem, input int pidx,
                            input logic b, input logic pd, input logic d);
        chk({tag, ".state"}, 64'(st1), 64'(st));
        chk({tag, ".rem"}, 64'(rem1), 64'(rem));
        chk({tag, ".pass_idx"}, 64'(pi1), 64'(pidx));
        chk({tag, ".busy"}, 64'(busy1), 64'(b));
        chk({tag, ".paused"}, 64'(pd1), 64'(pd));
        chk({tag, ".wash_done"}, 64'(done1), 64'(d));
    endtask

    task automatic add(input logic c, input logic [1:0] pr, input logic pa, input logic ab,
                       input logic [2:0] st, input int rem, input int pidx,
                       input logic b, input logic pd, input logic d);
        vec_t v;
        v.coin = c; v.preq = pr; v.pause = pa; v.abort = ab;
        v.st = st; v.rem = 8'(rem); v.pidx = 2'(pidx);
        v.busy = b; v.paused = pd; v.done = d;
        vecs.push_back(v);
    endtask

    // Start a cycle and follow both instances until each pulses wash_done;
    // n1/n2 are edges after the coin edge, -1 if the budget runs out.
    task automatic run_cycle(input logic [1:0] preq, output int n1, output int n2);
        logic [2:0] prev1, prev2;
        scode1 = '0; scode2 = '0; pcode1 = '0; pcode2 = '0;
        n1 = -1; n2 = -1;
        prev1 = IDLE; prev2 = IDLE;
        coin_in = 1'b1; pass_req = preq;
        step();
        coin_in = 1'b0; pass_req = 2'd0;
        for (int c = 0; c < 100; c++) begin
            if (st1 != prev1) begin
                scode1 = (scode1 << 3) | 64'(st1);
                pcode1 = (pcode1 << 2) | 64'(pi1);
                prev1  = st1;
            end
            if (st2 != prev2) begin
                scode2 = (scode2 << 3) | 64'(st2);
                pcode2 = (pcode2 << 2) | 64'(pi2);
                prev2  = st2;
            end
            if (done1 && n1 < 0) n1 = c;
            if (done2 && n2 < 0) n2 = c;
            if (n1 >= 0 && n2 >= 0) break;
            step();
        end
    endtask

    initial begin
        int n1, n2, cnt;

        rst_n = 1'b0; coin_in = 1'b0; pass_req = 2'd0; pause = 1'b0; abort = 1'b0;
        step();
        chk_outs("reset", IDLE, 0, 0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk_outs("post_reset", IDLE, 0, 0, 1'b0, 1'b0, 1'b0);

        // single-pass cycle, cycle by cycle; a coin mid-WASH and pause in IDLE are ignored
        add(1, 2'd1, 0, 0, FILL, 3, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, FILL, 2, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, FILL, 1, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, FILL, 0, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, WASH, 5, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, WASH, 4, 1, 1, 0, 0);
        add(1, 2'd3, 0, 0, WASH, 3, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, WASH, 2, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, WASH, 1, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, WASH, 0, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, RINSE, 2, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, RINSE, 1, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, RINSE, 0, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, SPIN, 1, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, SPIN, 0, 1, 1, 0, 0);
        add(0, 2'd0, 0, 0, IDLE, 0, 0, 0, 0, 1);
        add(0, 2'd0, 1, 0, IDLE, 0, 0, 0, 0, 0);
        add(0, 2'd0, 0, 0, IDLE, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            coin_in = vecs[i].coin; pass_req = vecs[i].preq;
            pause = vecs[i].pause; abort = vecs[i].abort;
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].st, int'(vecs[i].rem), int'(vecs[i].pidx),
                     vecs[i].busy, vecs[i].paused, vecs[i].done);
        end
        coin_in = 1'b0; pause = 1'b0;

        // two passes
        run_cycle(2'd2, n1, n2);
        chk("p2_len", 64'(n1), 64'(24));
        chk("p2_seq", scode1, 64'({FILL, WASH, RINSE, WASH, RINSE, SPIN, IDLE}));
        chk("p2_pidx", pcode1, 64'({2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0}));
        chk("p2_len_max2", 64'(n2), 64'(24));
        step();
        chk("p2_done_width", 64'(done1), 64'(0));

        // pass_req=0 clamps up to one pass
        run_cycle(2'd0, n1, n2);
        chk("p0_len", 64'(n1), 64'(15));
        chk("p0_seq", scode1, 64'({FILL, WASH, RINSE, SPIN, IDLE}));
        chk("p0_pidx", pcode1, 64'({2'd1, 2'd1, 2'd1, 2'd1, 2'd0}));

        // pass_req=3: three passes on MAX_PASS=3, clamped to two on MAX_PASS=2
        run_cycle(2'd3, n1, n2);
        chk("p3_len", 64'(n1), 64'(33));
        chk("p3_seq", scode1, 64'({FILL, WASH, RINSE, WASH, RINSE, WASH, RINSE, SPIN, IDLE}));
        chk("p3_pidx", pcode1, 64'({2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0}));
        chk("p3_len_max2", 64'(n2), 64'(24));
        chk("p3_seq_max2", scode2, 64'({FILL, WASH, RINSE, WASH, RINSE, SPIN, IDLE}));
        chk("p3_pidx_max2", pcode2, 64'({2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0}));
        step();

        // pause 5 cycles at WASH remaining_time=3
        coin_in = 1'b1; pass_req = 2'd1;
        step();
        coin_in = 1'b0; pass_req = 2'd0; cnt = 0;
        while ((st1 != WASH || rem1 != 8'd3) && cnt < 20) begin step(); cnt++; end
        chk("pause_reach", 64'(cnt), 64'(6));
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); cnt++;
            chk_outs($sformatf("pause%0d", i), WASH, 3, 1, 1'b1, 1'b1, 1'b0);
        end
        pause = 1'b0;
        step(); cnt++;
        chk_outs("resume", WASH, 2, 1, 1'b1, 1'b0, 1'b0);
        while (!done1 && cnt < 60) begin step(); cnt++; end
        chk("pause_done_at", 64'(cnt), 64'(20));
        step();

        // abort during RINSE with pause high, then a clean restart
        coin_in = 1'b1; pass_req = 2'd1;
        step();
        coin_in = 1'b0; pass_req = 2'd0; cnt = 0;
        while (st1 != RINSE && cnt < 30) begin step(); cnt++; end
        chk("abort_reach", 64'(cnt), 64'(10));
        pause = 1'b1;
        step();
        chk_outs("abort_pre", RINSE, 2, 1, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        step();
        chk_outs("abort_now", IDLE, 0, 0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0; pause = 1'b0;
        n1 = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done1) n1++;
        end
        chk("abort_no_done", 64'(n1), 64'(0));
        coin_in = 1'b1; pass_req = 2'd2;
        step();
        coin_in = 1'b0; pass_req = 2'd0;
        chk_outs("restart", FILL, 3, 1, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_outs("restart_abort", IDLE, 0, 0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-SPIN, then abort blocks a held coin
        coin_in = 1'b1; pass_req = 2'd1;
        step();
        coin_in = 1'b0; pass_req = 2'd0; cnt = 0;
        while (st1 != SPIN && cnt < 30) begin step(); cnt++; end
        chk("spin_reach", 64'(cnt), 64'(13));
        #2 rst_n = 1'b0;
        #1;
        chk_outs("async_rst", IDLE, 0, 0, 1'b0, 1'b0, 1'b0);
        step();
        chk_outs("rst_hold", IDLE, 0, 0, 1'b0, 1'b0, 1'b0);
        coin_in = 1'b1; abort = 1'b1; pass_req = 2'd1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs($sformatf("abort_blk%0d", i), IDLE, 0, 0, 1'b0, 1'b0, 1'b0);
        end
        abort = 1'b0;
        step();
        chk_outs("abort_release", FILL, 3, 1, 1'b1, 1'b0, 1'b0);
        coin_in = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
